// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard scoreboard for a non-forwarding 5-stage pipeline.
// One countdown counter per architectural register tracks when an in-flight write becomes readable in ID.
module hazard_scoreboard #(
  parameter int HAZ_DIST = 3,
  parameter int CNT_W    = $clog2(HAZ_DIST + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic        rd_wren,
  input  logic        flush,
  output logic        stall,
  output logic        issue,
  output logic        idex_bubble,
  output logic [31:0] busy_mask,
  output logic [31:0] stall_count
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HAZ_DIST);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [31:0]      stall_count_q;
  logic [31:0]      stall_count_d;
  logic             haz1;
  logic             haz2;

  always_comb begin
    haz1        = (rs1_addr != 5'd0) && (cnt_q[rs1_addr] != '0);
    haz2        = (rs2_addr != 5'd0) && (cnt_q[rs2_addr] != '0);
    stall       = id_valid && !flush && (haz1 || haz2);
    issue       = id_valid && !flush && !stall;
    idex_bubble = !issue;
  end

  // A fresh issue reloads its rd counter, overriding that register's decrement.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - ONE) : '0;
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (issue && rd_wren && (rd_addr == 5'(r))) begin
        cnt_d[r] = LOAD_VAL;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < 32; r++) begin
      busy_mask[r] = (cnt_q[r] != '0);
    end
  end

  assign stall_count = stall_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
      stall_count_q <= '0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: per-cycle vector table plus a distance-2 sequence
// run against both HAZ_DIST=3 and HAZ_DIST=2 instances sharing the same ID-stage stimulus.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rd_wren, flush;

  logic        stall, issue, idex_bubble;
  logic [31:0] busy_mask, stall_count;
  logic        stall2, issue2, idex_bubble2;
  logic [31:0] busy_mask2, stall_count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.HAZ_DIST(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rd_wren(rd_wren), .flush(flush),
    .stall(stall), .issue(issue), .idex_bubble(idex_bubble),
    .busy_mask(busy_mask), .stall_count(stall_count)
  );

  hazard_scoreboard #(.HAZ_DIST(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rd_wren(rd_wren), .flush(flush),
    .stall(stall2), .issue(issue2), .idex_bubble(idex_bubble2),
    .busy_mask(busy_mask2), .stall_count(stall_count2)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wren;
    logic        flush;
    logic        e_stall;
    logic        e_issue;
    logic        e_bub;
    logic [31:0] e_busy;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic v, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d, input logic w, input logic f,
                              input logic es, input logic ei, input logic eb,
                              input logic [31:0] ebusy, input logic [31:0] ecnt);
    vec_t t;
    t.rst = r; t.valid = v; t.rs1 = s1; t.rs2 = s2; t.rd = d; t.wren = w; t.flush = f;
    t.e_stall = es; t.e_issue = ei; t.e_bub = eb; t.e_busy = ebusy; t.e_cnt = ecnt;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic w, input logic f);
    @(negedge clk);
    rst = r; id_valid = v; rs1_addr = s1; rs2_addr = s2; rd_addr = d; rd_wren = w; flush = f;
    #2;
  endtask

  localparam logic [31:0] B3 = 32'h0000_0008;
  localparam logic [31:0] B5 = 32'h0000_0020;
  localparam logic [31:0] B7 = 32'h0000_0080;
  localparam logic [31:0] B8 = 32'h0000_0100;

  initial begin
    //                 rst v  rs1 rs2 rd  w  f   stall iss bub busy     count
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 32'h0,   0); // reset state
    vecs[1]  = mk(0, 1, 0, 0, 5, 1, 0,  0, 1, 0, 32'h0,   0); // addi x5
    vecs[2]  = mk(0, 1, 5, 0, 6, 0, 0,  1, 0, 1, B5,      0);
    vecs[3]  = mk(0, 1, 5, 0, 6, 0, 0,  1, 0, 1, B5,      1);
    vecs[4]  = mk(0, 1, 5, 0, 6, 0, 0,  1, 0, 1, B5,      2);
    vecs[5]  = mk(0, 1, 5, 0, 6, 0, 0,  0, 1, 0, 32'h0,   3);
    vecs[6]  = mk(0, 1, 0, 0, 5, 1, 0,  0, 1, 0, 32'h0,   3); // independent: write x5
    vecs[7]  = mk(0, 1, 6, 0, 10, 0, 0, 0, 1, 0, B5,      3); // read x6
    vecs[8]  = mk(0, 1, 0, 0, 0, 1, 0,  0, 1, 0, B5,      3); // write x0
    vecs[9]  = mk(0, 1, 0, 0, 0, 0, 0,  0, 1, 0, B5,      3); // read x0
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 32'h0,   3);
    vecs[11] = mk(0, 1, 0, 0, 5, 1, 0,  0, 1, 0, 32'h0,   3); // flush during stall
    vecs[12] = mk(0, 1, 0, 5, 0, 0, 0,  1, 0, 1, B5,      3);
    vecs[13] = mk(0, 1, 0, 5, 0, 0, 1,  0, 0, 1, B5,      4);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, B5,      4);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 32'h0,   4);
    vecs[16] = mk(0, 1, 0, 0, 9, 1, 1,  0, 0, 1, 32'h0,   4); // flushed writer x9
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 32'h0,   4);
    vecs[18] = mk(0, 1, 0, 0, 3, 1, 0,  0, 1, 0, 32'h0,   4); // rewrite x3
    vecs[19] = mk(0, 1, 0, 0, 3, 1, 0,  0, 1, 0, B3,      4);
    vecs[20] = mk(0, 1, 3, 0, 0, 0, 0,  1, 0, 1, B3,      4);
    vecs[21] = mk(0, 1, 3, 0, 0, 0, 0,  1, 0, 1, B3,      5);
    vecs[22] = mk(0, 1, 3, 0, 0, 0, 0,  1, 0, 1, B3,      6);
    vecs[23] = mk(0, 1, 3, 0, 0, 0, 0,  0, 1, 0, 32'h0,   7);
    vecs[24] = mk(0, 1, 0, 0, 8, 1, 0,  0, 1, 0, 32'h0,   7); // reset mid-operation
    vecs[25] = mk(0, 1, 0, 0, 5, 1, 0,  0, 1, 0, B8,      7);
    vecs[26] = mk(0, 1, 5, 0, 0, 0, 0,  1, 0, 1, B8 | B5, 7);
    vecs[27] = mk(1, 1, 5, 0, 0, 0, 0,  1, 0, 1, B8 | B5, 8);
    vecs[28] = mk(0, 1, 5, 0, 0, 0, 0,  0, 1, 0, 32'h0,   0);
    vecs[29] = mk(1, 1, 0, 0, 12, 1, 0, 0, 1, 0, 32'h0,   0); // reset beats issue load
    vecs[30] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 32'h0,   0);

    rst = 1'b1; id_valid = 1'b0; rs1_addr = '0; rs2_addr = '0; rd_addr = '0; rd_wren = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].wren, vecs[i].flush);
      check($sformatf("v%0d stall", i), {31'b0, stall}, {31'b0, vecs[i].e_stall});
      check($sformatf("v%0d issue", i), {31'b0, issue}, {31'b0, vecs[i].e_issue});
      check($sformatf("v%0d bubble", i), {31'b0, idex_bubble}, {31'b0, vecs[i].e_bub});
      check($sformatf("v%0d busy_mask", i), busy_mask, vecs[i].e_busy);
      check($sformatf("v%0d stall_count", i), stall_count, vecs[i].e_cnt);
    end

    // Distance 2: writer x7, unrelated op, then reader of rs2=7 held in ID.
    drive(0, 1, 0, 0, 7, 1, 0);
    check("d2 writer issue h3", {31'b0, issue}, 32'd1);
    check("d2 writer issue h2", {31'b0, issue2}, 32'd1);
    check("d2 count h2 start", stall_count2, 32'd0);
    drive(0, 1, 0, 0, 10, 0, 0);
    check("d2 unrelated issue h3", {31'b0, issue}, 32'd1);
    check("d2 unrelated issue h2", {31'b0, issue2}, 32'd1);
    check("d2 busy h2", busy_mask2, B7);
    drive(0, 1, 0, 7, 0, 0, 0);
    check("d2 c1 stall h3", {31'b0, stall}, 32'd1);
    check("d2 c1 stall h2", {31'b0, stall2}, 32'd1);
    check("d2 c1 busy h2", busy_mask2, B7);
    drive(0, 1, 0, 7, 0, 0, 0);
    check("d2 c2 stall h3", {31'b0, stall}, 32'd1);
    check("d2 c2 issue h2", {31'b0, issue2}, 32'd1);
    check("d2 c2 bubble h2", {31'b0, idex_bubble2}, 32'd0);
    check("d2 c2 busy h2", busy_mask2, 32'h0);
    drive(0, 1, 0, 7, 0, 0, 0);
    check("d2 c3 issue h3", {31'b0, issue}, 32'd1);
    check("d2 c3 busy h3", busy_mask, 32'h0);
    check("d2 stall_count h3", stall_count, 32'd2);
    check("d2 stall_count h2", stall_count2, 32'd1);

    drive(0, 0, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
